// File: rtl/div_seq_pkg.sv
// Shared definitions for the EX-stage divide sequencer.
// These are the state encodings that the hazard unit and the debug views see.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor,
// and keep the difference when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // rem_in < divisor always holds, so the true difference fits in WIDTH bits
    // and the modular low-half subtract gives it exactly.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign fits    = shifted >= {1'b0, divisor};
    assign diff    = shifted[WIDTH-1:0] - divisor;
    assign rem_out = fits ? diff : shifted[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: one restoring step per cycle,
// sign fixup on completion, {remainder, quotient} held for HI/LO writeback.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sign,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    input  logic               cancel,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e         state, state_nxt;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0]   rem_step, quo_step;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q, sign_r, divz;
    logic               ready_q;
    logic [2*WIDTH-1:0] result_q;
    logic               accept, last_iter, opb_zero;

    function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? neg2c(v) : v;
    endfunction

    assign accept    = start & ~cancel;
    assign opb_zero  = (opb == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH-1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cancel) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (accept) state_nxt = opb_zero ? DIV_DONE : DIV_BUSY;
                DIV_BUSY: if (last_iter) state_nxt = DIV_DONE;
                DIV_DONE: state_nxt = DIV_IDLE;
                default:  state_nxt = DIV_IDLE;
            endcase
        end
    end

    // A zero divisor parks the raw dividend in rem_q and all-ones in quo_q,
    // so DONE can publish it without the sign fixup.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            divz     <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        sign_q <= sign & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        sign_r <= sign & opa[WIDTH-1];
                        cnt    <= '0;
                        divz   <= opb_zero;
                        dvs_q  <= abs_val(opb, sign);
                        rem_q  <= opb_zero ? opa : '0;
                        quo_q  <= opb_zero ? '1 : abs_val(opa, sign);
                    end
                end
                DIV_BUSY: begin
                    if (!cancel) begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                DIV_DONE: begin
                    if (!cancel) begin
                        ready_q <= 1'b1;
                        if (divz)
                            result_q <= {rem_q, quo_q};
                        else
                            result_q <= {sign_r ? neg2c(rem_q) : rem_q,
                                         sign_q ? neg2c(quo_q) : quo_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != DIV_IDLE);
    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide-by-zero,
// cancel, back-to-back starts and mid-divide reset.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst, start, sign, cancel;
    logic [31:0] opa, opb;
    logic        busy, ready;
    logic [63:0] result;

    int vectors = 0;
    int miscompares = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sign   (sign),
        .opa    (opa),
        .opb    (opb),
        .cancel (cancel),
        .busy   (busy),
        .ready  (ready),
        .result (result)
    );

    always #5 clk = ~clk;

    // Holds start until ready; lat = index of the edge (0 = accepting edge) after which ready is seen.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res);
        start = 1'b1; sign = s; opa = a; opb = b;
        lat = -1; res = '0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = k;
                res = result;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sign = 1'b0; cancel = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", ready); end
        vectors++; if (result !== 64'd0) begin miscompares++; $display("FAIL reset_result got %h exp 0", result); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_divu();
        int lat; logic [63:0] res;
        do_div(1'b0, 32'd100, 32'd7, lat, res);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL divu_latency got %0d exp 33", lat); end
        vectors++; if (res !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL divu_result got %h exp %h", res, {32'd2, 32'd14}); end
        @(posedge clk); #1;
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL divu_single_pulse got %b exp 0", ready); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL divu_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_signed();
        int lat; logic [63:0] res;
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, res);
        vectors++; if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin miscompares++; $display("FAIL div_m7_2 got %h exp ffffffff_fffffffd", res); end
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL div_signed_latency got %0d exp 33", lat); end
        @(posedge clk); #1;
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, lat, res);
        vectors++; if (res !== {32'd1, 32'hFFFFFFFD}) begin miscompares++; $display("FAIL div_7_m2 got %h exp 00000001_fffffffd", res); end
        @(posedge clk); #1;
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
        vectors++; if (res !== {32'd0, 32'h80000000}) begin miscompares++; $display("FAIL div_minint got %h exp 00000000_80000000", res); end
        @(posedge clk); #1;
        do_div(1'b0, 32'hFFFFFFF9, 32'd2, lat, res);
        vectors++; if (res !== {32'd1, 32'h7FFFFFFC}) begin miscompares++; $display("FAIL divu_big got %h exp 00000001_7ffffffc", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int lat; logic [63:0] res;
        do_div(1'b0, 32'd5, 32'd0, lat, res);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL divz_latency got %0d exp 1", lat); end
        vectors++; if (res !== {32'd5, 32'hFFFFFFFF}) begin miscompares++; $display("FAIL divz_result got %h exp 00000005_ffffffff", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_cancel();
        int lat; int pulses; logic [63:0] res;
        start = 1'b1; sign = 1'b0; opa = 32'd1000; opb = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cancel_busy_before got %b exp 1", busy); end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL cancel_busy_after got %b exp 0", busy); end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL cancel_no_ready got %0d exp 0", pulses); end
        vectors++; if (result !== {32'd5, 32'hFFFFFFFF}) begin miscompares++; $display("FAIL cancel_result_kept got %h exp 00000005_ffffffff", result); end
        do_div(1'b0, 32'd1000, 32'd3, lat, res);
        vectors++; if (lat !== 33) begin miscompares++; $display("FAIL cancel_restart_latency got %0d exp 33", lat); end
        vectors++; if (res !== {32'd1, 32'd333}) begin miscompares++; $display("FAIL cancel_restart_result got %h exp 00000001_0000014d", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int npulse; int edge1; int edge2; logic [63:0] r1, r2;
        npulse = 0; edge1 = -1; edge2 = -1; r1 = '0; r2 = '0;
        start = 1'b1; sign = 1'b0; opa = 32'd100; opb = 32'd7;
        for (int k = 0; k < 76; k++) begin
            @(posedge clk); #1;
            if (k == 5)  begin opa = 32'd1000; opb = 32'd7; end
            if (k == 40) begin opa = 32'd0; opb = 32'd1; end
            if (ready) begin
                npulse++;
                if (npulse == 1) begin edge1 = k; r1 = result; end
                if (npulse == 2) begin edge2 = k; r2 = result; start = 1'b0; end
            end
        end
        start = 1'b0;
        vectors++; if (npulse !== 2) begin miscompares++; $display("FAIL b2b_pulse_count got %0d exp 2", npulse); end
        vectors++; if (edge1 !== 33) begin miscompares++; $display("FAIL b2b_first_edge got %0d exp 33", edge1); end
        vectors++; if (edge2 - edge1 !== 34) begin miscompares++; $display("FAIL b2b_spacing got %0d exp 34", edge2 - edge1); end
        vectors++; if (r1 !== {32'd2, 32'd14}) begin miscompares++; $display("FAIL b2b_result1 got %h exp 00000002_0000000e", r1); end
        vectors++; if (r2 !== {32'd6, 32'd142}) begin miscompares++; $display("FAIL b2b_result2 got %h exp 00000006_0000008e", r2); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; sign = 1'b0; opa = 32'd100; opb = 32'd7;
        repeat (16) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before got %b exp 1", busy); end
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        vectors++; if (ready !== 1'b0)   begin miscompares++; $display("FAIL rstmid_ready got %b exp 0", ready); end
        vectors++; if (result !== 64'd0) begin miscompares++; $display("FAIL rstmid_result got %h exp 0", result); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
